core_fetch: RTL and testbench

CORE_FETCH -- requirements
Module: core_fetch

---
 rtl/core_fetch.sv | 146 ++++++++++++++
 tb/tb_core_fetch.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch.sv
// Instruction fetch: credit-limited bus requests, 2-entry in-order response buffer, registered decode output.
// Latency: grant -> response -> inst_out one edge after the response; hold freezes the output and credits stall fetching.
module core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_flag_in,
    output logic        ibus_req_out,
    output logic [31:0] ibus_addr_out,
    input  logic        ibus_gnt_in,
    input  logic        ibus_rvalid_in,
    input  logic [31:0] ibus_rdata_in,
    output logic        inst_valid_out,
    output logic [31:0] inst_out,
    output logic [31:0] inst_addr_out
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  out_cnt_q, out_cnt_d;
    logic        out_rd_q, out_rd_d, out_wr_q, out_wr_d;
    logic [31:0] out_addr_q [2];
    logic [3:0]  discard_q, discard_d;
    logic [1:0]  buf_cnt_q, buf_cnt_d;
    logic        buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
    logic [31:0] buf_addr_q [2];
    logic [31:0] buf_data_q [2];
    logic        req_en_q;
    logic        inst_valid_q, inst_valid_d;
    logic [31:0] inst_q, inst_d, inst_addr_q, inst_addr_d;

    logic        credit_ok, grant, rsp_keep, rsp_drop, advance, pop, bypass, push;
    logic [31:0] rsp_addr;

    assign credit_ok     = ({1'b0, out_cnt_q} + {1'b0, buf_cnt_q}) < 3'd2;
    assign ibus_req_out  = req_en_q & ~jump_flag_in & credit_ok;
    assign ibus_addr_out = fetch_pc_q & 32'hFFFF_FFFC;
    assign grant         = ibus_req_out & ibus_gnt_in;
    // Responses are in order, so the old stream's leftovers always arrive first.
    assign rsp_drop      = ibus_rvalid_in & (discard_q != 4'd0);
    assign rsp_keep      = ibus_rvalid_in & (discard_q == 4'd0);
    assign rsp_addr      = out_addr_q[out_rd_q];
    assign advance       = ~jump_flag_in & ~hold_flag_in;
    assign pop           = advance & (buf_cnt_q != 2'd0);
    assign bypass        = advance & (buf_cnt_q == 2'd0) & rsp_keep;
    assign push          = rsp_keep & ~jump_flag_in & ~bypass;

    assign inst_valid_out = inst_valid_q;
    assign inst_out       = inst_q;
    assign inst_addr_out  = inst_addr_q;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        out_cnt_d    = out_cnt_q;
        out_rd_d     = out_rd_q;
        out_wr_d     = out_wr_q;
        discard_d    = discard_q;
        buf_cnt_d    = buf_cnt_q;
        buf_rd_d     = buf_rd_q;
        buf_wr_d     = buf_wr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_addr_d  = inst_addr_q;
        if (jump_flag_in) begin
            fetch_pc_d   = jump_addr_in & 32'hFFFF_FFFC;
            // Everything still in flight becomes a discard; a response this cycle is one of them.
            discard_d    = discard_q + {2'b00, out_cnt_q} - {3'b000, ibus_rvalid_in};
            out_cnt_d    = 2'd0;
            out_rd_d     = 1'b0;
            out_wr_d     = 1'b0;
            buf_cnt_d    = 2'd0;
            buf_rd_d     = 1'b0;
            buf_wr_d     = 1'b0;
            inst_valid_d = 1'b0;
            inst_d       = NOP_INST;
        end else begin
            if (grant) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                out_wr_d   = ~out_wr_q;
            end
            if (rsp_keep) out_rd_d = ~out_rd_q;
            if (rsp_drop) discard_d = discard_q - 4'd1;
            out_cnt_d = out_cnt_q + {1'b0, grant} - {1'b0, rsp_keep};
            if (push) buf_wr_d = ~buf_wr_q;
            if (pop)  buf_rd_d = ~buf_rd_q;
            buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};
            if (advance) begin
                if (pop) begin
                    inst_valid_d = 1'b1;
                    inst_d       = buf_data_q[buf_rd_q];
                    inst_addr_d  = buf_addr_q[buf_rd_q];
                end else if (bypass) begin
                    inst_valid_d = 1'b1;
                    inst_d       = ibus_rdata_in;
                    inst_addr_d  = rsp_addr;
                end else begin
                    inst_valid_d = 1'b0;
                    inst_d       = NOP_INST;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q   <= RESET_PC;
            out_cnt_q    <= 2'd0;
            out_rd_q     <= 1'b0;
            out_wr_q     <= 1'b0;
            discard_q    <= 4'd0;
            buf_cnt_q    <= 2'd0;
            buf_rd_q     <= 1'b0;
            buf_wr_q     <= 1'b0;
            req_en_q     <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            inst_addr_q  <= 32'd0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            out_cnt_q    <= out_cnt_d;
            out_rd_q     <= out_rd_d;
            out_wr_q     <= out_wr_d;
            discard_q    <= discard_d;
            buf_cnt_q    <= buf_cnt_d;
            buf_rd_q     <= buf_rd_d;
            buf_wr_q     <= buf_wr_d;
            req_en_q     <= 1'b1;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_addr_q  <= inst_addr_d;
        end
    end

    // Storage only; validity is carried by the reset counters above.
    always_ff @(posedge clk) begin
        if (grant) out_addr_q[out_wr_q] <= ibus_addr_out;
        if (push) begin
            buf_addr_q[buf_wr_q] <= rsp_addr;
            buf_data_q[buf_wr_q] <= ibus_rdata_in;
        end
    end

endmodule

// File: tb/tb_core_fetch.sv
// Bench for core_fetch: in-order bus with random latency and a stream-level reference model.
module tb_core_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_flag_in = 1'b0;
    logic [31:0] jump_addr_in = 32'd0;
    logic        hold_flag_in = 1'b0;
    logic        ibus_req_out;
    logic [31:0] ibus_addr_out;
    logic        ibus_gnt_in = 1'b0;
    logic        ibus_rvalid_in = 1'b0;
    logic [31:0] ibus_rdata_in = 32'd0;
    logic        inst_valid_out;
    logic [31:0] inst_out;
    logic [31:0] inst_addr_out;

    core_fetch #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
        .clk(clk), .rst(rst),
        .jump_flag_in(jump_flag_in), .jump_addr_in(jump_addr_in), .hold_flag_in(hold_flag_in),
        .ibus_req_out(ibus_req_out), .ibus_addr_out(ibus_addr_out), .ibus_gnt_in(ibus_gnt_in),
        .ibus_rvalid_in(ibus_rvalid_in), .ibus_rdata_in(ibus_rdata_in),
        .inst_valid_out(inst_valid_out), .inst_out(inst_out), .inst_addr_out(inst_addr_out)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int epoch; int due; } rsp_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; } ent_t;

    int n_cmp = 0;
    int n_bad = 0;
    rsp_t pend[$];
    ent_t ready_q[$];
    int epoch = 0, cyc = 0, last_due = 0, lat_min = 1, lat_max = 1;
    logic [31:0] pc = RESET_PC;
    logic [31:0] mem_key = 32'd0;
    bit started = 1'b0;
    logic        n_valid = 1'b0;
    logic [31:0] n_inst = NOP, n_iaddr = 32'd0;
    logic        e_valid, e_req, s_valid, s_req;
    logic [31:0] e_inst, e_iaddr, e_addr, s_inst, s_iaddr, s_addr;

    // Reference: every current-stream response becomes available in order; an unheld edge
    // presents the oldest available one, a jump flushes the stream.
    task automatic reset_model();
        pend.delete();
        ready_q.delete();
        epoch++;
        pc = RESET_PC;
        started = 1'b0;
        n_valid = 1'b0;
        n_inst = NOP;
        n_iaddr = 32'd0;
        last_due = cyc;
    endtask

    task automatic step();
        int curp;
        bit grant;
        rsp_t r;
        ent_t en;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            ibus_rvalid_in = 1'b1;
            ibus_rdata_in  = pend[0].addr ^ mem_key;
        end else begin
            ibus_rvalid_in = 1'b0;
            ibus_rdata_in  = $urandom;
        end
        @(negedge clk);
        curp = 0;
        foreach (pend[i]) if (pend[i].epoch == epoch) curp++;
        e_req   = started && !jump_flag_in && (curp + ready_q.size() < 2);
        e_addr  = pc;
        e_valid = n_valid;
        e_inst  = n_inst;
        e_iaddr = n_iaddr;
        s_req   = ibus_req_out;
        s_addr  = ibus_addr_out;
        s_valid = inst_valid_out;
        s_inst  = inst_out;
        s_iaddr = inst_addr_out;
        grant = ibus_req_out && ibus_gnt_in;
        if (ibus_rvalid_in) begin
            r = pend.pop_front();
            if (r.epoch == epoch && !jump_flag_in) begin
                en.addr = r.addr;
                en.data = ibus_rdata_in;
                ready_q.push_back(en);
            end
        end
        if (grant) begin
            r.addr  = ibus_addr_out;
            r.epoch = epoch;
            r.due   = cyc + $urandom_range(lat_max, lat_min);
            if (r.due <= last_due) r.due = last_due + 1;
            last_due = r.due;
            pend.push_back(r);
        end
        if (jump_flag_in) begin
            pc = jump_addr_in & ~32'd3;
            epoch++;
            ready_q.delete();
            n_valid = 1'b0;
            n_inst  = NOP;
        end else begin
            if (grant) pc = pc + 32'd4;
            if (!hold_flag_in) begin
                if (ready_q.size() > 0) begin
                    en = ready_q.pop_front();
                    n_valid = 1'b1;
                    n_inst  = en.data;
                    n_iaddr = en.addr;
                end else begin
                    n_valid = 1'b0;
                    n_inst  = NOP;
                end
            end
        end
        started = 1'b1;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (ibus_req_out !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", ibus_req_out); end
        n_cmp++; if (inst_valid_out !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", inst_valid_out); end
        n_cmp++; if (inst_out !== NOP) begin n_bad++; $display("FAIL reset_inst got %h want %h", inst_out, NOP); end
        n_cmp++; if (inst_addr_out !== 32'd0) begin n_bad++; $display("FAIL reset_iaddr got %h want 0", inst_addr_out); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
    endtask

    task automatic test_stream();
        mem_key = 32'd0; lat_min = 1; lat_max = 1; ibus_gnt_in = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 0) begin
                n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL stream_first_req got %b want 0", s_req); end
            end
            if (k >= 3) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_iaddr !== 32'(4 * (k - 3)) || s_inst !== 32'(4 * (k - 3))) begin
                    n_bad++;
                    $display("FAIL stream_seq k=%0d got v=%b a=%h i=%h want v=1 a=%h i=%h", k, s_valid, s_iaddr, s_inst, 4 * (k - 3), 4 * (k - 3));
                end
            end
        end
    endtask

    task automatic test_hold();
        logic v_valid;
        logic [31:0] v_inst, v_iaddr;
        mem_key = 32'hC0DE_0000;
        repeat (2) step();
        hold_flag_in = 1'b1;
        step();
        v_valid = s_valid; v_inst = s_inst; v_iaddr = s_iaddr;
        n_cmp++; if (v_valid !== 1'b1) begin n_bad++; $display("FAIL hold_pre_valid got %b want 1", v_valid); end
        for (int i = 0; i < 5; i++) begin
            if (i == 4) hold_flag_in = 1'b0;
            step();
            n_cmp++;
            if (s_valid !== v_valid || s_inst !== v_inst || s_iaddr !== v_iaddr) begin
                n_bad++;
                $display("FAIL hold_frozen i=%0d got v=%b a=%h i=%h want v=%b a=%h i=%h", i, s_valid, s_iaddr, s_inst, v_valid, v_iaddr, v_inst);
            end
            if (i >= 1 && i <= 3) begin
                n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL hold_credit_full i=%0d req got %b want 0", i, s_req); end
            end
        end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++;
            if (s_valid !== 1'b1 || s_iaddr !== v_iaddr + 32'(4 * i) || s_inst !== ((v_iaddr + 32'(4 * i)) ^ mem_key)) begin
                n_bad++;
                $display("FAIL hold_resume i=%0d got v=%b a=%h i=%h want v=1 a=%h", i, s_valid, s_iaddr, s_inst, v_iaddr + 32'(4 * i));
            end
        end
    endtask

    task automatic test_gnt_low();
        logic p_req;
        logic [31:0] p_addr;
        ibus_gnt_in = 1'b1;
        repeat (3) step();
        ibus_gnt_in = 1'b0;
        step();
        p_req = s_req; p_addr = s_addr;
        n_cmp++; if (p_req !== 1'b1) begin n_bad++; $display("FAIL gntlow_req_start got %b want 1", p_req); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++;
            if (s_req !== p_req || s_addr !== p_addr) begin
                n_bad++;
                $display("FAIL gntlow_stable i=%0d got req=%b addr=%h want req=%b addr=%h", i, s_req, s_addr, p_req, p_addr);
            end
            n_cmp++;
            if (s_valid !== e_valid || s_inst !== e_inst || (e_valid && s_iaddr !== e_iaddr)) begin
                n_bad++;
                $display("FAIL gntlow_out i=%0d got v=%b a=%h i=%h want v=%b a=%h i=%h", i, s_valid, s_iaddr, s_inst, e_valid, e_iaddr, e_inst);
            end
        end
        ibus_gnt_in = 1'b1;
    endtask

    task automatic test_jump();
        int curp;
        bit got;
        lat_min = 4; lat_max = 4; ibus_gnt_in = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            curp = 0;
            foreach (pend[k]) if (pend[k].epoch == epoch) curp++;
            if (curp == 2 && ready_q.size() == 0) got = 1'b1;
        end
        n_cmp++; if (!got) begin n_bad++; $display("FAIL jump_setup got no_two_outstanding want two_outstanding"); end
        jump_flag_in = 1'b1; jump_addr_in = 32'h0000_0103;
        step();
        jump_flag_in = 1'b0; lat_min = 1; lat_max = 1;
        n_cmp++; if (s_req !== 1'b0) begin n_bad++; $display("FAIL jump_req_forced got %b want 0", s_req); end
        step();
        n_cmp++; if (s_valid !== 1'b0) begin n_bad++; $display("FAIL jump_valid got %b want 0", s_valid); end
        n_cmp++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin n_bad++; $display("FAIL jump_next_addr got req=%b addr=%h want req=1 addr=00000100", s_req, s_addr); end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (s_valid === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (!got || s_iaddr !== 32'h100 || s_inst !== (32'h100 ^ mem_key)) begin
            n_bad++;
            $display("FAIL jump_first_valid got seen=%b a=%h i=%h want a=00000100 i=%h", got, s_iaddr, s_inst, 32'h100 ^ mem_key);
        end
    endtask

    task automatic test_jump_hold();
        repeat (4) step();
        n_cmp++; if (s_valid !== 1'b1) begin n_bad++; $display("FAIL jh_pre_valid got %b want 1", s_valid); end
        jump_flag_in = 1'b1; hold_flag_in = 1'b1; jump_addr_in = 32'h0000_0200;
        step();
        jump_flag_in = 1'b0; hold_flag_in = 1'b0;
        step();
        n_cmp++;
        if (s_valid !== 1'b0 || s_inst !== NOP) begin
            n_bad++;
            $display("FAIL jh_flush got v=%b i=%h want v=0 i=%h", s_valid, s_inst, NOP);
        end
    endtask

    task automatic test_random();
        lat_min = 1; lat_max = 3; mem_key = $urandom;
        for (int c = 0; c < 400; c++) begin
            ibus_gnt_in  = ($urandom_range(0, 9) < 7);
            hold_flag_in = ($urandom_range(0, 9) < 2);
            jump_flag_in = ($urandom_range(0, 24) == 0);
            jump_addr_in = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF6 : ($urandom & 32'h0000_03FF);
            step();
            n_cmp++; if (s_valid !== e_valid) begin n_bad++; $display("FAIL rnd_valid c=%0d got %b want %b", c, s_valid, e_valid); end
            n_cmp++; if (s_inst !== e_inst) begin n_bad++; $display("FAIL rnd_inst c=%0d got %h want %h", c, s_inst, e_inst); end
            if (e_valid) begin
                n_cmp++; if (s_iaddr !== e_iaddr) begin n_bad++; $display("FAIL rnd_iaddr c=%0d got %h want %h", c, s_iaddr, e_iaddr); end
            end
            n_cmp++; if (s_req !== e_req) begin n_bad++; $display("FAIL rnd_req c=%0d got %b want %b", c, s_req, e_req); end
            n_cmp++; if (s_addr !== e_addr) begin n_bad++; $display("FAIL rnd_addr c=%0d got %h want %h", c, s_addr, e_addr); end
        end
        jump_flag_in = 1'b0; hold_flag_in = 1'b0; ibus_gnt_in = 1'b1;
    endtask

    task automatic test_async_reset();
        lat_min = 1; lat_max = 1; ibus_gnt_in = 1'b1;
        repeat (6) step();
        #3 rst = 1'b1;
        #1;
        n_cmp++; if (ibus_req_out !== 1'b0) begin n_bad++; $display("FAIL areset_req got %b want 0", ibus_req_out); end
        n_cmp++; if (inst_valid_out !== 1'b0) begin n_bad++; $display("FAIL areset_valid got %b want 0", inst_valid_out); end
        n_cmp++; if (inst_out !== NOP) begin n_bad++; $display("FAIL areset_inst got %h want %h", inst_out, NOP); end
        n_cmp++; if (inst_addr_out !== 32'd0) begin n_bad++; $display("FAIL areset_iaddr got %h want 0", inst_addr_out); end
        n_cmp++; if (ibus_addr_out !== RESET_PC) begin n_bad++; $display("FAIL areset_pc got %h want %h", ibus_addr_out, RESET_PC); end
        ibus_rvalid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_model();
        for (int k = 0; k < 6; k++) begin
            step();
            if (k >= 3) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_iaddr !== RESET_PC + 32'(4 * (k - 3))) begin
                    n_bad++;
                    $display("FAIL areset_restart k=%0d got v=%b a=%h want v=1 a=%h", k, s_valid, s_iaddr, RESET_PC + 32'(4 * (k - 3)));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_gnt_low();
        test_jump();
        test_jump_hold();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
